// File: rtl/ec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ec_pkg
// Description : Shared definitions for the EC scalar-multiplication sequencer:
//               EC core operation codes, FSM state encoding and the default
//               sizing of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ec_pkg;

  // Default sizing of the sequencer
  localparam int          KW_DEF      = 256;
  localparam int          OPW_DEF     = 3;
  localparam int          TMO_W_DEF   = 16;
  localparam logic [15:0] TMO_MAX_DEF = 16'hFFFF;

  // Operation codes understood by the EC core
  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_LOAD    = 3'd1;  // Q = P
  localparam logic [2:0] OP_DBL     = 3'd2;  // Q = 2Q
  localparam logic [2:0] OP_ADD     = 3'd3;  // Q = Q + P
  localparam logic [2:0] OP_DADD    = 3'd4;  // dummy add, result discarded
  localparam logic [2:0] OP_NOP_DBL = 3'd5;  // dummy double, result discarded

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_FIN   = 3'd5,
    ST_FAIL  = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ec_smul_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : ec_smul_seq_if
// Description : Command interface between the scalar-multiplication sequencer
//               (master) and the EC core (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ec_smul_seq_if
  import ec_pkg::*;
#(
  parameter int OPW = OPW_DEF
) ();

  logic [OPW-1:0] ec_op;   // operation code, meaningful while ec_en is high
  logic           ec_en;   // one-cycle command strobe
  logic           ec_clr;  // one-cycle core clear
  logic           ec_rdy;  // one-cycle completion pulse from the core

  modport master (output ec_op, output ec_en, output ec_clr, input ec_rdy);
  modport slave  (input ec_op, input ec_en, input ec_clr, output ec_rdy);

endinterface
`default_nettype wire

// File: rtl/ec_smul_wdog.sv
`default_nettype none
// ============================================================================
// Module      : ec_smul_wdog
// Description : Per-operation watchdog. Counter is cleared (loaded with zero)
//               by clr, advances while en is high and flags a timeout on the
//               enabled cycle that would bring it to TMO_MAX.
// Revision    : 1.0 - initial release
// ============================================================================
module ec_smul_wdog #(
  parameter int               TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_MAX = '1
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clr,
  input  wire logic en,
  output logic      tmo
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - 1'b1;

  logic [TMO_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and hold at TMO_MAX
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != TMO_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tmo = en && !clr && (cnt_q == TMO_LAST);

endmodule
`default_nettype wire

// File: rtl/ec_smul_seq.sv
`default_nettype none
// ============================================================================
// Module      : ec_smul_seq
// Description : Left-to-right double-and-add sequencer for Q = k*P. Issues one
//               point operation at a time to the EC core and waits for its
//               completion, with a per-operation watchdog and an abort path.
//               Optional macro EC_SMUL_CONST_TIME_EN selects a constant-time
//               schedule (no leading-zero skip, dummy double/add operations).
// Revision    : 1.0 - initial release
// ============================================================================
module ec_smul_seq
  import ec_pkg::*;
#(
  parameter int               KW      = KW_DEF,
  parameter int               OPW     = OPW_DEF,
  parameter int               TMO_W   = TMO_W_DEF,
  parameter logic [TMO_W-1:0] TMO_MAX = TMO_W'(TMO_MAX_DEF)
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          start,
  input  wire logic          abort,
  input  wire logic [KW-1:0] k,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               inf,
  output logic [15:0]        op_cnt,
  ec_smul_seq_if.master      ec
);

  localparam int             IW       = (KW > 1) ? $clog2(KW) : 1;
  localparam logic [IW-1:0]  IDX_TOP  = IW'(KW - 1);
  localparam logic [OPW-1:0] C_OP_NOP  = OPW'(OP_NOP);
  localparam logic [OPW-1:0] C_OP_LOAD = OPW'(OP_LOAD);
  localparam logic [OPW-1:0] C_OP_DBL  = OPW'(OP_DBL);
  localparam logic [OPW-1:0] C_OP_ADD  = OPW'(OP_ADD);
`ifdef EC_SMUL_CONST_TIME_EN
  localparam logic [OPW-1:0] C_OP_DADD    = OPW'(OP_DADD);
  localparam logic [OPW-1:0] C_OP_NOP_DBL = OPW'(OP_NOP_DBL);
`endif

  state_e         state_q, state_d;
  logic [KW-1:0]  scal_q, scal_d;      // scalar, current bit is always the MSB
  logic [IW-1:0]  idx_q, idx_d;        // index of the bit sitting in the MSB
  logic [OPW-1:0] pend_q, pend_d;      // operation most recently issued
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           inf_q, inf_d;
  logic [15:0]    op_cnt_q, op_cnt_d;
  logic [OPW-1:0] ec_op_q, ec_op_d;
  logic           ec_en_q, ec_en_d;
  logic           ec_clr_q, ec_clr_d;
`ifdef EC_SMUL_CONST_TIME_EN
  logic           started_q, started_d;  // a 1 bit has been consumed (Q valid)
  logic           dslot_q, dslot_d;      // last op was the double of an iteration
`endif

  logic           issue;
  logic [OPW-1:0] issue_op;
  logic           wd_clr, wd_en, wd_tmo;
  logic           cur_bit;

  assign cur_bit = scal_q[KW-1];
  assign wd_en   = (state_q == ST_WAIT) && !ec.ec_rdy;

  ec_smul_wdog #(
    .TMO_W   (TMO_W),
    .TMO_MAX (TMO_MAX)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wd_clr),
    .en    (wd_en),
    .tmo   (wd_tmo)
  );

  // Next-state and registered-output logic; outputs are set on the transition
  // into a state so that they are valid during that state
  always_comb begin
    state_d  = state_q;
    scal_d   = scal_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    inf_d    = inf_q;
    op_cnt_d = op_cnt_q;
    ec_op_d  = C_OP_NOP;
    ec_en_d  = 1'b0;
    ec_clr_d = 1'b0;
    wd_clr   = 1'b0;
    issue    = 1'b0;
    issue_op = C_OP_NOP;
`ifdef EC_SMUL_CONST_TIME_EN
    started_d = started_q;
    dslot_d   = dslot_q;
`endif

    if ((state_q != ST_IDLE) && abort) begin
      // abort beats a coincident ec_rdy or timeout
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      ec_clr_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            scal_d   = k;
            idx_d    = IDX_TOP;
            busy_d   = 1'b1;
            inf_d    = 1'b0;
            op_cnt_d = '0;
            ec_clr_d = 1'b1;
            state_d  = ST_SCAN;
`ifdef EC_SMUL_CONST_TIME_EN
            started_d = 1'b0;
            dslot_d   = 1'b0;
`endif
          end
        end

        ST_SCAN: begin
`ifdef EC_SMUL_CONST_TIME_EN
          // top bit always costs one op, dummy when it is zero
          issue     = 1'b1;
          issue_op  = cur_bit ? C_OP_LOAD : C_OP_NOP_DBL;
          started_d = cur_bit;
`else
          if (scal_q == '0) begin
            inf_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_FIN;
          end else if (cur_bit) begin
            issue    = 1'b1;
            issue_op = C_OP_LOAD;
          end else begin
            scal_d = scal_q << 1;
            idx_d  = idx_q - 1'b1;
          end
`endif
        end

        ST_ISSUE: begin
          wd_clr  = 1'b1;
          state_d = ST_WAIT;
        end

        ST_WAIT: begin
          if (ec.ec_rdy) begin
            state_d = ST_NEXT;
          end else if (wd_tmo) begin
            err_d    = 1'b1;
            ec_clr_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_FAIL;
          end
        end

        ST_NEXT: begin
`ifdef EC_SMUL_CONST_TIME_EN
          if (dslot_q) begin
            // second half of an iteration: real or dummy add
            dslot_d   = 1'b0;
            issue     = 1'b1;
            issue_op  = !cur_bit  ? C_OP_DADD :
                        started_q ? C_OP_ADD  : C_OP_LOAD;
            started_d = started_q | cur_bit;
          end else if (idx_q == '0) begin
            inf_d   = !started_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_FIN;
          end else begin
            scal_d   = scal_q << 1;
            idx_d    = idx_q - 1'b1;
            dslot_d  = 1'b1;
            issue    = 1'b1;
            issue_op = started_q ? C_OP_DBL : C_OP_NOP_DBL;
          end
`else
          if ((pend_q == C_OP_DBL) && cur_bit) begin
            issue    = 1'b1;
            issue_op = C_OP_ADD;
          end else if (idx_q == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_FIN;
          end else begin
            scal_d   = scal_q << 1;
            idx_d    = idx_q - 1'b1;
            issue    = 1'b1;
            issue_op = C_OP_DBL;
          end
`endif
        end

        ST_FIN:  state_d = ST_IDLE;
        ST_FAIL: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase

      if (issue) begin
        pend_d   = issue_op;
        ec_op_d  = issue_op;
        ec_en_d  = 1'b1;
        op_cnt_d = (op_cnt_q == 16'hFFFF) ? op_cnt_q : op_cnt_q + 16'd1;
        state_d  = ST_ISSUE;
      end
    end
  end

  // FSM and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      scal_q    <= '0;
      idx_q     <= '0;
      pend_q    <= C_OP_NOP;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      inf_q     <= 1'b0;
      op_cnt_q  <= '0;
      ec_op_q   <= C_OP_NOP;
      ec_en_q   <= 1'b0;
      ec_clr_q  <= 1'b0;
`ifdef EC_SMUL_CONST_TIME_EN
      started_q <= 1'b0;
      dslot_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      scal_q    <= scal_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      inf_q     <= inf_d;
      op_cnt_q  <= op_cnt_d;
      ec_op_q   <= ec_op_d;
      ec_en_q   <= ec_en_d;
      ec_clr_q  <= ec_clr_d;
`ifdef EC_SMUL_CONST_TIME_EN
      started_q <= started_d;
      dslot_q   <= dslot_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign inf       = inf_q;
  assign op_cnt    = op_cnt_q;
  assign ec.ec_op  = ec_op_q;
  assign ec.ec_en  = ec_en_q;
  assign ec.ec_clr = ec_clr_q;

endmodule
`default_nettype wire

// File: tb/tb_ec_smul_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ec_smul_seq
// Description : Self-checking bench for ec_smul_seq with an EC core model that
//               answers each command after a programmable latency, and a
//               reference model that derives the expected operation stream
//               directly from the bits of k. Honours EC_SMUL_CONST_TIME_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ec_smul_seq;
  import ec_pkg::*;

  localparam int KW  = 256;
  localparam int TMO = 16;
`ifdef EC_SMUL_CONST_TIME_EN
  localparam int CT_OPS = 1 + 2 * (KW - 1);
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, abort;
  logic [KW-1:0] k_in;
  logic          busy, done, err, inf;
  logic [15:0]   op_cnt;

  always #5 clk = ~clk;

  ec_smul_seq_if #(.OPW(3)) ec_if ();

  ec_smul_seq #(
    .KW(KW), .OPW(3), .TMO_W(16), .TMO_MAX(16'(TMO))
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .k(k_in),
    .busy(busy), .done(done), .err(err), .inf(inf), .op_cnt(op_cnt),
    .ec(ec_if)
  );

  int n_tests = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, rdy_cd = 0, rdy_lat = 4;
  int withhold_op = 0, abort_op = 0;
  bit abort_arm = 0, abort_hit = 0;
  int abort_cyc = 0, last_rdy_cyc = 0, done_cyc = 0, err_cyc = 0, clr_cyc = 0;
  int n_en = 0, n_done = 0, n_err = 0, overlap = 0;
  logic [2:0] ops[$];
  logic [2:0] exp_ops[$];
  int         en_t[$];
  bit         exp_inf;

  // EC core model and monitor, evaluated just after every rising edge
  initial begin
    ec_if.ec_rdy = 1'b0;
    abort = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      ec_if.ec_rdy = 1'b0;
      abort = 1'b0;
      if (!rst_n) rdy_cd = 0;
      if (rdy_cd > 0) begin
        rdy_cd--;
        if (rdy_cd == 0) begin
          ec_if.ec_rdy = 1'b1;
          last_rdy_cyc = cyc;
          if (abort_arm && n_en == abort_op) begin
            abort = 1'b1; abort_arm = 0; abort_hit = 1; abort_cyc = cyc;
          end
        end
      end
      if (ec_if.ec_en === 1'b1) begin
        ops.push_back(ec_if.ec_op);
        en_t.push_back(cyc - start_cyc);
        n_en++;
        if (n_en != withhold_op) rdy_cd = rdy_lat;
      end
      if (ec_if.ec_en === 1'b1 && ec_if.ec_clr === 1'b1) overlap++;
      if (done === 1'b1) begin n_done++; done_cyc = cyc; end
      if (err === 1'b1) begin n_err++; err_cyc = cyc; end
      if (ec_if.ec_clr === 1'b1) clr_cyc = cyc;
    end
  end

  // Reference: binary left-to-right method expressed on the bits of k
  task automatic build_exp(input logic [KW-1:0] kv);
    bit seen = 0;
    exp_ops.delete();
    exp_inf = (kv == '0);
`ifdef EC_SMUL_CONST_TIME_EN
    for (int i = KW - 1; i >= 0; i--) begin
      if (i == KW - 1) begin
        exp_ops.push_back(kv[i] ? OP_LOAD : OP_NOP_DBL);
      end else begin
        exp_ops.push_back(seen ? OP_DBL : OP_NOP_DBL);
        exp_ops.push_back(kv[i] ? (seen ? OP_ADD : OP_LOAD) : OP_DADD);
      end
      seen = seen | kv[i];
    end
`else
    for (int i = KW - 1; i >= 0; i--) begin
      if (seen) exp_ops.push_back(OP_DBL);
      if (kv[i]) exp_ops.push_back(seen ? OP_ADD : OP_LOAD);
      seen = seen | kv[i];
    end
`endif
  endtask

  function automatic int seq_diff();
    int d = 0;
    if (ops.size() != exp_ops.size()) d++;
    for (int i = 0; i < ops.size() && i < exp_ops.size(); i++)
      if (ops[i] !== exp_ops[i]) d++;
    return d;
  endfunction

  task automatic clear_run();
    ops.delete(); en_t.delete();
    n_en = 0; n_done = 0; n_err = 0; rdy_cd = 0;
    withhold_op = 0; abort_arm = 0; abort_hit = 0;
  endtask

  // Pulse start with kv, then wait (bounded) for done or err
  task automatic run_k(input logic [KW-1:0] kv, input int lat);
    bit fin = 0;
    rdy_lat = lat;
    @(negedge clk);
    k_in = kv; start = 1'b1; start_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (n_done + n_err > 0) begin fin = 1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!fin) begin n_fail++; $display("FAIL run_bound k=%h: no done/err within 20000 cycles", kv); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; k_in = '0;
    repeat (3) @(negedge clk);
    n_tests += 8;
    if (busy !== 1'b0)    begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    if (done !== 1'b0)    begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
    if (err !== 1'b0)     begin n_fail++; $display("FAIL rst_err got %b want 0", err); end
    if (inf !== 1'b0)     begin n_fail++; $display("FAIL rst_inf got %b want 0", inf); end
    if (op_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_op_cnt got %0d want 0", op_cnt); end
    if (ec_if.ec_op !== OP_NOP) begin n_fail++; $display("FAIL rst_ec_op got %0d want 0", ec_if.ec_op); end
    if (ec_if.ec_en !== 1'b0)  begin n_fail++; $display("FAIL rst_ec_en got %b want 0", ec_if.ec_en); end
    if (ec_if.ec_clr !== 1'b0) begin n_fail++; $display("FAIL rst_ec_clr got %b want 0", ec_if.ec_clr); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero();
    clear_run();
    run_k('0, 4);
    n_tests += 4;
    if (inf !== 1'b1) begin n_fail++; $display("FAIL zero_inf got %b want 1", inf); end
    if (n_done !== 1) begin n_fail++; $display("FAIL zero_done got %0d pulses want 1", n_done); end
`ifdef EC_SMUL_CONST_TIME_EN
    if (n_en !== CT_OPS) begin n_fail++; $display("FAIL zero_en got %0d strobes want %0d", n_en, CT_OPS); end
    if (op_cnt !== 16'(CT_OPS)) begin n_fail++; $display("FAIL zero_op_cnt got %0d want %0d", op_cnt, CT_OPS); end
`else
    if (n_en !== 0) begin n_fail++; $display("FAIL zero_en got %0d strobes want 0", n_en); end
    if (op_cnt !== 16'd0) begin n_fail++; $display("FAIL zero_op_cnt got %0d want 0", op_cnt); end
    n_tests++;
    if (done_cyc - start_cyc > 2) begin n_fail++; $display("FAIL zero_latency got %0d cycles want <=2", done_cyc - start_cyc); end
`endif
  endtask

  task automatic test_small();
    logic [KW-1:0] kv;
    for (int t = 0; t < 2; t++) begin
      kv = (t == 0) ? KW'(1) : KW'(5);
      clear_run();
      build_exp(kv);
      run_k(kv, 4);
      n_tests += 4;
      if (seq_diff() != 0) begin n_fail++; $display("FAIL small_ops k=%0d: %0d diffs (got %0d ops want %0d)", kv, seq_diff(), ops.size(), exp_ops.size()); end
      if (op_cnt !== 16'(exp_ops.size())) begin n_fail++; $display("FAIL small_op_cnt k=%0d got %0d want %0d", kv, op_cnt, exp_ops.size()); end
      if (inf !== 1'b0) begin n_fail++; $display("FAIL small_inf k=%0d got %b want 0", kv, inf); end
      if (done_cyc <= last_rdy_cyc || done_cyc > last_rdy_cyc + 2) begin
        n_fail++; $display("FAIL small_done_lat k=%0d got %0d cycles after last ec_rdy want 1..2", kv, done_cyc - last_rdy_cyc);
      end
    end
  endtask

  task automatic test_random();
    logic [KW-1:0] kv;
    int lat;
    for (int t = 0; t < 5; t++) begin
      kv = '0;
      if (t < 2) for (int w = 0; w < KW / 32; w++) kv[w*32 +: 32] = $urandom();
      else kv[31:0] = $urandom() >> $urandom_range(0, 28);
      if (kv == '0) kv[0] = 1'b1;
      lat = $urandom_range(1, 6);
      clear_run();
      build_exp(kv);
      run_k(kv, lat);
      n_tests += 4;
      if (seq_diff() != 0) begin n_fail++; $display("FAIL rand_ops k=%h: %0d diffs (got %0d ops want %0d)", kv, seq_diff(), ops.size(), exp_ops.size()); end
      if (op_cnt !== 16'(exp_ops.size())) begin n_fail++; $display("FAIL rand_op_cnt got %0d want %0d", op_cnt, exp_ops.size()); end
      if (inf !== exp_inf) begin n_fail++; $display("FAIL rand_inf got %b want %b", inf, exp_inf); end
      if (n_err !== 0) begin n_fail++; $display("FAIL rand_err got %0d pulses want 0", n_err); end
    end
  endtask

  task automatic test_timeout();
    clear_run();
    withhold_op = 2;
    run_k(KW'(6), 4);
    n_tests += 6;
    if (n_err !== 1)  begin n_fail++; $display("FAIL tmo_err got %0d pulses want 1", n_err); end
    if (n_done !== 0) begin n_fail++; $display("FAIL tmo_done got %0d pulses want 0", n_done); end
    if (en_t.size() < 2 || err_cyc - start_cyc != en_t[1] + TMO + 1) begin
      n_fail++; $display("FAIL tmo_time got err at %0d want %0d", err_cyc - start_cyc, (en_t.size() < 2) ? -1 : en_t[1] + TMO + 1);
    end
    if (clr_cyc !== err_cyc) begin n_fail++; $display("FAIL tmo_clr got clr at %0d want %0d", clr_cyc, err_cyc); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy got %b want 0", busy); end
    if (op_cnt !== 16'd2) begin n_fail++; $display("FAIL tmo_op_cnt got %0d want 2", op_cnt); end
  endtask

  task automatic test_abort();
    logic [KW-1:0] kv;
    bit hit = 0;
    clear_run();
    abort_arm = 1; abort_op = 3; rdy_lat = 4;
    @(negedge clk);
    k_in = KW'(8'hFF); start = 1'b1; start_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (abort_hit) begin hit = 1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!hit) begin n_fail++; $display("FAIL abort_reach got no abort point want abort on op 3"); end
    @(negedge clk);
    n_tests += 2;
    if (ec_if.ec_clr !== 1'b1) begin n_fail++; $display("FAIL abort_clr got %b want 1", ec_if.ec_clr); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    repeat (30) @(negedge clk);
    n_tests += 2;
    if (n_done !== 0) begin n_fail++; $display("FAIL abort_done got %0d pulses want 0", n_done); end
    if (n_err !== 0)  begin n_fail++; $display("FAIL abort_err got %0d pulses want 0", n_err); end
    // restart after abort
    kv = '0; kv[15:0] = 16'($urandom_range(1, 65535));
    clear_run();
    build_exp(kv);
    run_k(kv, 3);
    n_tests += 2;
    if (seq_diff() != 0) begin n_fail++; $display("FAIL abort_restart_ops k=%h: %0d diffs", kv, seq_diff()); end
    if (n_done !== 1) begin n_fail++; $display("FAIL abort_restart_done got %0d want 1", n_done); end
  endtask

  task automatic test_busy_start();
    logic [KW-1:0] kv;
    kv = '0; kv[11:0] = 12'($urandom_range(2048, 4095));
    clear_run();
    build_exp(kv);
    rdy_lat = 5;
    @(negedge clk);
    k_in = kv; start = 1'b1; start_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    k_in = ~kv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20000 && n_done + n_err == 0; i++) @(negedge clk);
    n_tests += 3;
    if (seq_diff() != 0) begin n_fail++; $display("FAIL busy_start_ops k=%h: %0d diffs", kv, seq_diff()); end
    if (n_done !== 1) begin n_fail++; $display("FAIL busy_start_done got %0d want 1", n_done); end
    if (overlap !== 0) begin n_fail++; $display("FAIL en_clr_overlap got %0d cycles want 0", overlap); end
  endtask

`ifdef EC_SMUL_CONST_TIME_EN
  task automatic test_const_time();
    int t5[$];
    logic [KW-1:0] kv;
    clear_run();
    kv = KW'(5);
    run_k(kv, 3);
    t5 = en_t;
    n_tests++;
    if (op_cnt !== 16'(CT_OPS)) begin n_fail++; $display("FAIL ct_cnt_k5 got %0d want %0d", op_cnt, CT_OPS); end
    clear_run();
    kv = '0; kv[KW-1] = 1'b1;
    build_exp(kv);
    run_k(kv, 3);
    n_tests += 3;
    if (op_cnt !== 16'(CT_OPS)) begin n_fail++; $display("FAIL ct_cnt_msb got %0d want %0d", op_cnt, CT_OPS); end
    if (seq_diff() != 0) begin n_fail++; $display("FAIL ct_ops_msb %0d diffs", seq_diff()); end
    begin
      int d = (t5.size() == en_t.size()) ? 0 : 1;
      for (int i = 0; i < t5.size() && i < en_t.size(); i++) if (t5[i] != en_t[i]) d++;
      if (d != 0) begin n_fail++; $display("FAIL ct_timing got %0d strobe time diffs want 0", d); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_small();
    test_random();
    test_timeout();
    test_abort();
    test_busy_start();
`ifdef EC_SMUL_CONST_TIME_EN
    test_const_time();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
